// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog reset sequencer.
// WDT_LOCKOUT_EN widens the state type to add the LOCKED state.
package wdt_pkg;

    localparam int unsigned DEF_GRACE_CYCLES = 1024;
    localparam int unsigned DEF_RST_CYCLES   = 16;

`ifdef WDT_LOCKOUT_EN
    localparam int unsigned ST_W = 3;
`else
    localparam int unsigned ST_W = 2;
`endif

    // Low two bits of each encoding are what state_o reports.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = ST_W'(0),
        ST_WARN    = ST_W'(1),
        ST_RESET   = ST_W'(2),
        ST_RECOVER = ST_W'(3)
`ifdef WDT_LOCKOUT_EN
        , ST_LOCKED = ST_W'(4)
`endif
    } wdt_state_e;

    function automatic logic [31:0] rcnt_sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wdt_cycle_timer.sv
// Up-counter with clear, enable and an equal-to-limit flag; shared by the grace and reset windows.
module wdt_cycle_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_c_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_c_o = (cnt_q == limit_i);

endmodule

// File: rtl/wdt_reset_sequencer.sv
// Watchdog timeout consumer: warn via irq, escalate to a timed system reset, track cause and count.
// Define WDT_LOCKOUT_EN to hold sys_rst_o permanently after MAX_RESETS watchdog resets.
module wdt_reset_sequencer
    import wdt_pkg::*;
#(
    parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RCNT_W       = 4
`ifdef WDT_LOCKOUT_EN
    , parameter int unsigned MAX_RESETS = 7
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wdt_tmo,
    input  logic              ack,
    input  logic              cause_clr,
    output logic              irq_o,
    output logic              sys_rst_o,
    output logic              wdt_clr_o,
    output logic              cause_o,
    output logic [RCNT_W-1:0] rst_cnt_o,
    output logic [1:0]        state_o
);

    localparam logic [31:0] RCNT_MAX = (32'd1 << RCNT_W) - 32'd1;

    wdt_state_e        state_q, state_d;
    logic              irq_q, irq_d;
    logic              sys_rst_q, sys_rst_d;
    logic              wdt_clr_q, wdt_clr_d;
    logic              cause_q, cause_d;
    logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]        state_o_q, state_o_d;

    logic              tmr_clr_c, tmr_en_c, tmr_hit_c, rst_entry_c;
    logic [CNT_W-1:0]  tmr_limit_c;

    // Timer restarts on every state change and only runs in the timed states.
    assign tmr_clr_c   = (state_d != state_q);
    assign tmr_en_c    = (state_q == ST_WARN) || (state_q == ST_RESET);
    assign tmr_limit_c = (state_q == ST_RESET) ? CNT_W'(RST_CYCLES - 1) : CNT_W'(GRACE_CYCLES - 1);

    wdt_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr_c),
        .en_i    (tmr_en_c),
        .limit_i (tmr_limit_c),
        .hit_c_o (tmr_hit_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            sys_rst_q <= 1'b0;
            wdt_clr_q <= 1'b0;
            cause_q   <= 1'b0;
            rst_cnt_q <= '0;
            state_o_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            sys_rst_q <= sys_rst_d;
            wdt_clr_q <= wdt_clr_d;
            cause_q   <= cause_d;
            rst_cnt_q <= rst_cnt_d;
            state_o_q <= state_o_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_entry_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wdt_tmo) state_d = ST_WARN;
            end
            // Ack beats both escalation and grace expiry.
            ST_WARN: begin
                if (ack)                        state_d = ST_IDLE;
                else if (wdt_tmo || tmr_hit_c)  state_d = ST_RESET;
            end
            ST_RESET: begin
`ifdef WDT_LOCKOUT_EN
                if (tmr_hit_c) state_d = (32'(rst_cnt_q) >= MAX_RESETS) ? ST_LOCKED : ST_RECOVER;
`else
                if (tmr_hit_c) state_d = ST_RECOVER;
`endif
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
`ifdef WDT_LOCKOUT_EN
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rst_entry_c = (state_d == ST_RESET) && (state_q != ST_RESET);

        irq_d     = (state_d == ST_WARN);
        sys_rst_d = (state_d == ST_RESET);
        wdt_clr_d = (state_d == ST_RESET) || ((state_q == ST_WARN) && (state_d == ST_IDLE));
        state_o_d = 2'(state_d);
        rst_cnt_d = rst_entry_c ? RCNT_W'(rcnt_sat_inc(32'(rst_cnt_q), RCNT_MAX)) : rst_cnt_q;

        // Set beats clear when both land in the same cycle.
        if (rst_entry_c)    cause_d = 1'b1;
        else if (cause_clr) cause_d = 1'b0;
        else                cause_d = cause_q;

`ifdef WDT_LOCKOUT_EN
        if (state_d == ST_LOCKED) begin
            sys_rst_d = 1'b1;
            wdt_clr_d = 1'b1;
            state_o_d = 2'd3;
            cause_d   = cause_q;
        end
`endif
    end

    assign irq_o     = irq_q;
    assign sys_rst_o = sys_rst_q;
    assign wdt_clr_o = wdt_clr_q;
    assign cause_o   = cause_q;
    assign rst_cnt_o = rst_cnt_q;
    assign state_o   = state_o_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Scoreboard bench for wdt_reset_sequencer with GRACE_CYCLES=8, RST_CYCLES=4.
// With WDT_LOCKOUT_EN defined, MAX_RESETS=2 and the lockout scenario replaces the saturation one.
module tb_wdt_reset_sequencer;

    localparam int unsigned G = 8;
    localparam int unsigned R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wdt_tmo = 1'b0;
    logic       ack = 1'b0;
    logic       cause_clr = 1'b0;
    logic       irq_o, sys_rst_o, wdt_clr_o, cause_o;
    logic [3:0] rst_cnt_o;
    logic [1:0] state_o;

    typedef struct packed {
        logic       irq;
        logic       srst;
        logic       wclr;
        logic       cause;
        logic [3:0] cnt;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];
    obs_t e, o;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    wdt_reset_sequencer #(
        .GRACE_CYCLES (G),
        .RST_CYCLES   (R),
        .CNT_W        (16),
        .RCNT_W       (4)
`ifdef WDT_LOCKOUT_EN
        , .MAX_RESETS (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wdt_tmo   (wdt_tmo),
        .ack       (ack),
        .cause_clr (cause_clr),
        .irq_o     (irq_o),
        .sys_rst_o (sys_rst_o),
        .wdt_clr_o (wdt_clr_o),
        .cause_o   (cause_o),
        .rst_cnt_o (rst_cnt_o),
        .state_o   (state_o)
    );

    function automatic obs_t sample();
        obs_t r;
        r = {irq_o, sys_rst_o, wdt_clr_o, cause_o, rst_cnt_o, state_o};
        return r;
    endfunction

    // Inputs driven in cycle cyc are sampled at the edge closing it; outputs read 1ns later.
    task automatic step(input logic r, input logic t, input logic a, input logic c);
        rst = r; wdt_tmo = t; ack = a; cause_clr = c;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cyc = 0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            step(1'b1, 1'b1, 1'b1, 1'b1);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL reset i=%0d got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_ack();
        apply_reset();
        for (int c = 0; c < 25; c++) begin
            int n;
            n = c + 1;
            e = '0;
            e.irq  = (n >= 11 && n <= 13);
            e.wclr = (n == 14);
            e.st   = e.irq ? 2'd1 : 2'd0;
            exp_q.push_back(e);
            step(1'b0, c == 10, c == 5 || c == 13, c == 7);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL ack cyc=%0d got=%h want=%h", cyc, o, e); end
        end
    endtask

    // Grace expiry; tmo/ack during RESET and tmo during RECOVER must be ignored.
    task automatic test_grace_expiry();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            int n;
            n = c + 1;
            e = '0;
            e.irq   = (n >= 11 && n <= 10 + G);
            e.srst  = (n >= 11 + G && n <= 10 + G + R);
            e.wclr  = e.srst;
            e.cause = (n >= 11 + G);
            e.cnt   = (n >= 11 + G) ? 4'd1 : 4'd0;
            e.st    = e.irq ? 2'd1 : e.srst ? 2'd2 : (n == 11 + G + R) ? 2'd3 : 2'd0;
            exp_q.push_back(e);
            step(1'b0, c == 10 || c == 20 || c == 23, c == 21, 1'b0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL grace cyc=%0d got=%h want=%h", cyc, o, e); end
        end
    endtask

    task automatic test_escalation();
        apply_reset();
        for (int c = 0; c < 25; c++) begin
            int n;
            n = c + 1;
            e = '0;
            e.irq   = (n >= 11 && n <= 12);
            e.srst  = (n >= 13 && n <= 12 + R);
            e.wclr  = e.srst;
            e.cause = (n >= 13);
            e.cnt   = (n >= 13) ? 4'd1 : 4'd0;
            e.st    = e.irq ? 2'd1 : e.srst ? 2'd2 : (n == 13 + R) ? 2'd3 : 2'd0;
            exp_q.push_back(e);
            step(1'b0, c == 10 || c == 12, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL escal cyc=%0d got=%h want=%h", cyc, o, e); end
        end
    endtask

    // Mode 0: ack with escalation; mode 1: ack on the last grace cycle.
    task automatic test_ack_priority();
        for (int m = 0; m < 2; m++) begin
            int ack_c;
            ack_c = (m == 0) ? 12 : 10 + G;
            apply_reset();
            for (int c = 0; c < 25; c++) begin
                int n;
                n = c + 1;
                e = '0;
                e.irq  = (n >= 11 && n <= ack_c);
                e.wclr = (n == ack_c + 1);
                e.st   = e.irq ? 2'd1 : 2'd0;
                exp_q.push_back(e);
                step(1'b0, c == 10 || (m == 0 && c == 12), c == ack_c, 1'b0);
                e = exp_q.pop_front(); o = sample(); total++;
                if (o !== e) begin bad++; $display("FAIL ackprio m=%0d cyc=%0d got=%h want=%h", m, cyc, o, e); end
            end
        end
    endtask

    // Clear before set is a no-op, clear on the entry cycle loses, later clear wins.
    task automatic test_cause_clr();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            int n;
            n = c + 1;
            e = '0;
            e.irq   = (n >= 11 && n <= 10 + G);
            e.srst  = (n >= 11 + G && n <= 10 + G + R);
            e.wclr  = e.srst;
            e.cause = (n >= 11 + G && n <= 26);
            e.cnt   = (n >= 11 + G) ? 4'd1 : 4'd0;
            e.st    = e.irq ? 2'd1 : e.srst ? 2'd2 : (n == 11 + G + R) ? 2'd3 : 2'd0;
            exp_q.push_back(e);
            step(1'b0, c == 10, 1'b0, c == 15 || c == 10 + G || c == 26);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL cause cyc=%0d got=%h want=%h", cyc, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 25; c++) begin
            int n;
            n = c + 1;
            e = '0;
            e.irq   = (n >= 11 && n <= 10 + G);
            e.srst  = (n >= 11 + G && n <= 20);
            e.wclr  = e.srst;
            e.cause = e.srst;
            e.cnt   = e.srst ? 4'd1 : 4'd0;
            e.st    = e.irq ? 2'd1 : e.srst ? 2'd2 : 2'd0;
            exp_q.push_back(e);
            step(c == 20, c == 10, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL rstmid cyc=%0d got=%h want=%h", cyc, o, e); end
        end
    endtask

`ifndef WDT_LOCKOUT_EN
    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            logic [3:0] want_cnt;
            want_cnt = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            exp_q.push_back('{irq: 1'b0, srst: 1'b1, wclr: 1'b1, cause: 1'b1, cnt: want_cnt, st: 2'd2});
            step(1'b0, 1'b1, 1'b0, k == 0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL sat_entry k=%0d got=%h want=%h", k, o, e); end
            exp_q.push_back('{irq: 1'b0, srst: 1'b0, wclr: 1'b0, cause: 1'b1, cnt: want_cnt, st: 2'd0});
            for (int s = 0; s < int'(R) + 1; s++) step(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL sat_idle k=%0d got=%h want=%h", k, o, e); end
        end
    endtask
`else
    // wclr is left unchecked while LOCKED.
    task automatic test_lockout();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            exp_q.push_back('{irq: 1'b0, srst: 1'b1, wclr: 1'b1, cause: 1'b1, cnt: 4'(k + 1), st: 2'd2});
            step(1'b0, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL lock_entry k=%0d got=%h want=%h", k, o, e); end
            for (int s = 0; s < int'(R); s++) step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 0) exp_q.push_back('{irq: 1'b0, srst: 1'b0, wclr: 1'b0, cause: 1'b1, cnt: 4'd1, st: 2'd3});
            else        exp_q.push_back('{irq: 1'b0, srst: 1'b1, wclr: 1'b0, cause: 1'b1, cnt: 4'd2, st: 2'd3});
            e = exp_q.pop_front(); o = sample(); o.wclr = 1'b0; total++;
            if (o !== e) begin bad++; $display("FAIL lock_post k=%0d got=%h want=%h", k, o, e); end
            if (k == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            exp_q.push_back('{irq: 1'b0, srst: 1'b1, wclr: 1'b0, cause: 1'b1, cnt: 4'd2, st: 2'd3});
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = exp_q.pop_front(); o = sample(); o.wclr = 1'b0; total++;
            if (o !== e) begin bad++; $display("FAIL locked i=%0d got=%h want=%h", i, o, e); end
        end
        exp_q.push_back('0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL lock_rst got=%h want=%h", o, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_ack();
        test_grace_expiry();
        test_escalation();
        test_ack_priority();
        test_cause_clr();
        test_reset_mid();
`ifndef WDT_LOCKOUT_EN
        test_saturation();
`else
        test_lockout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
